vga_out: RTL and testbench

- 640x480 @60 Hz VGA scan-out engine on a 25 MHz pixel clock.
- Generates active-low HSYNC/VSYNC and fetches an 8-bit RGB332 framebuffer from shared SRAM, one 32-bit word per request.
- The framebuffer holds a logical 160x120 image; each logical pixel is shown as a 4x4 block.
- Sits between the SRAM arbiter and the VGA DAC/pins.

---
 rtl/vga_out.sv | 237 +++++++++++++++++++++++
 tb/tb_vga_out.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_out.sv
// vga_out: 640x480 @60 Hz VGA scan-out engine (25 MHz pixel clock).
//
// A logical 160x120 RGB332 image is fetched from shared SRAM one 32-bit word
// (four logical pixels) at a time. Each logical pixel is shown as a 4x4 block.
// Two word buffers are used. current_word is on screen, and next_word is
// prefetched during the previous 16-pixel slot.
//
// Ports:
//   clk                in   25 MHz pixel clock
//   nrst               in   asynchronous active-low reset
//   SRAM_data_in[31:0] in   read data, byte 0 = leftmost pixel of the word
//   SRAM_busy          in   high while the SRAM is servicing a request
//   data_en            out  one-cycle read request strobe
//   h_out / v_out      out  HSYNC / VSYNC, active low
//   pixel_data[7:0]    out  RGB332 {R[2:0],G[2:0],B[1:0]}
//   word_address_dest  out  SRAM word address of the current request
//   byte_select[3:0]   out  4'b1111 while data_en=1, else 4'b0000
//   VGA_state[1:0]     out  fetch FSM state (0 IDLE,1 REQUEST,2 WAIT,3 LATCH)
//
// Build option: define VGA_OUT_TEST_PATTERN_EN to replace SRAM scan-out with an
// XOR test pattern. In that build no SRAM requests are issued.

module vga_out #(
  parameter logic [31:0] FB_BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] WORDS_PER_ROW = 32'd40
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] SRAM_data_in,
  input  logic        SRAM_busy,
  output logic        data_en,
  output logic        h_out,
  output logic        v_out,
  output logic [7:0]  pixel_data,
  output logic [31:0] word_address_dest,
  output logic [3:0]  byte_select,
  output logic [1:0]  VGA_state
);

  localparam logic [9:0] H_VISIBLE      = 10'd640;
  localparam logic [9:0] H_SYNC_START   = 10'd656;
  localparam logic [9:0] H_SYNC_END     = 10'd751;
  localparam logic [9:0] H_LAST         = 10'd799;
  localparam logic [9:0] H_PREFETCH_END = 10'd624;
  localparam logic [9:0] H_NEXT_LINE    = 10'd784;
  localparam logic [9:0] V_VISIBLE      = 10'd480;
  localparam logic [9:0] V_SYNC_START   = 10'd490;
  localparam logic [9:0] V_SYNC_END     = 10'd491;
  localparam logic [9:0] V_LAST         = 10'd524;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_WAIT    = 2'd2,
    ST_LATCH   = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [9:0]  v_next_s;
  logic        swap_s;
  logic        active_s;
  logic        h_sync_s;
  logic        v_sync_s;
  logic        trig_s;
  logic [6:0]  fetch_row_s;
  logic [5:0]  fetch_word_s;
  logic [31:0] fetch_addr_s;
  logic [31:0] fetch_data_r;
  logic [31:0] current_word_r;
  logic [31:0] next_word_r;
  logic        next_valid_r;
  logic        discard_r;
  logic [31:0] display_word_s;
  logic [7:0]  lane_pix_s;
  logic [7:0]  pix_src_s;

  assign v_next_s     = (v_cnt_r == V_LAST) ? 10'd0 : (v_cnt_r + 10'd1);
  assign swap_s       = (h_cnt_r[3:0] == 4'd0);
  assign active_s     = (h_cnt_r < H_VISIBLE) && (v_cnt_r < V_VISIBLE);
  assign h_sync_s     = (h_cnt_r >= H_SYNC_START) && (h_cnt_r <= H_SYNC_END);
  assign v_sync_s     = (v_cnt_r >= V_SYNC_START) && (v_cnt_r <= V_SYNC_END);
  assign fetch_addr_s = FB_BASE_ADDR + ({25'd0, fetch_row_s} * WORDS_PER_ROW)
                        + {26'd0, fetch_word_s};

  // Horizontal / vertical scan counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= v_next_s;
    end else begin
      h_cnt_r <= h_cnt_r + 10'd1;
    end
  end

  // Prefetch trigger: the next word of this line, or word 0 of the next line at h=784.
  always_comb begin
    trig_s       = 1'b0;
    fetch_row_s  = 7'd0;
    fetch_word_s = 6'd0;
    if (swap_s) begin
      if ((h_cnt_r < H_PREFETCH_END) && (v_cnt_r < V_VISIBLE)) begin
        trig_s       = 1'b1;
        fetch_row_s  = v_cnt_r[8:2];
        fetch_word_s = h_cnt_r[9:4] + 6'd1;
      end else if ((h_cnt_r == H_NEXT_LINE) && (v_next_s < V_VISIBLE)) begin
        trig_s       = 1'b1;
        fetch_row_s  = v_next_s[8:2];
        fetch_word_s = 6'd0;
      end else begin
        trig_s = 1'b0;
      end
    end else begin
      trig_s = 1'b0;
    end
`ifdef VGA_OUT_TEST_PATTERN_EN
    trig_s = 1'b0;
`endif
  end

  // Fetch FSM next-state logic. WAIT holds until the SRAM drops busy.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) state_next_s = ST_REQUEST;
        else        state_next_s = ST_IDLE;
      end
      ST_REQUEST: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (!SRAM_busy) state_next_s = ST_LATCH;
        else            state_next_s = ST_WAIT;
      end
      ST_LATCH: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // SRAM request outputs and read-data capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_en           <= 1'b0;
      byte_select       <= 4'b0000;
      word_address_dest <= 32'd0;
      fetch_data_r      <= 32'd0;
    end else begin
      data_en     <= (state_next_s == ST_REQUEST);
      byte_select <= (state_next_s == ST_REQUEST) ? 4'b1111 : 4'b0000;
      if ((state_r == ST_IDLE) && trig_s) begin
        word_address_dest <= fetch_addr_s;
      end else begin
        word_address_dest <= word_address_dest;
      end
      if ((state_r == ST_WAIT) && !SRAM_busy) begin
        fetch_data_r <= SRAM_data_in;
      end else begin
        fetch_data_r <= fetch_data_r;
      end
    end
  end

  // Word buffers. A fetch still in flight at a swap point has missed its slot.
  // Its data is dropped instead of being shown one slot late.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      current_word_r <= 32'd0;
      next_word_r    <= 32'd0;
      next_valid_r   <= 1'b0;
      discard_r      <= 1'b0;
    end else if (swap_s) begin
      current_word_r <= next_valid_r ? next_word_r : 32'd0;
      next_valid_r   <= 1'b0;
      discard_r      <= (state_r == ST_REQUEST) || (state_r == ST_WAIT);
    end else if (state_r == ST_LATCH) begin
      if (!discard_r) begin
        next_word_r  <= fetch_data_r;
        next_valid_r <= 1'b1;
      end else begin
        next_valid_r <= next_valid_r;
      end
      discard_r <= 1'b0;
    end else begin
      discard_r <= discard_r;
    end
  end

  // Pixel source. At a swap point the incoming word is selected directly, so
  // the first pixel of each slot is not taken from the old word.
  always_comb begin
    display_word_s = current_word_r;
    if (swap_s) begin
      if (next_valid_r) display_word_s = next_word_r;
      else              display_word_s = 32'd0;
    end else begin
      display_word_s = current_word_r;
    end
    case (h_cnt_r[3:2])
      2'd0:    lane_pix_s = display_word_s[7:0];
      2'd1:    lane_pix_s = display_word_s[15:8];
      2'd2:    lane_pix_s = display_word_s[23:16];
      2'd3:    lane_pix_s = display_word_s[31:24];
      default: lane_pix_s = 8'd0;
    endcase
`ifdef VGA_OUT_TEST_PATTERN_EN
    pix_src_s = h_cnt_r[9:2] ^ v_cnt_r[9:2];
`else
    pix_src_s = lane_pix_s;
`endif
  end

  // Sync and pixel outputs, registered from the same counter values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_out      <= 1'b1;
      v_out      <= 1'b1;
      pixel_data <= 8'd0;
    end else begin
      h_out      <= ~h_sync_s;
      v_out      <= ~v_sync_s;
      pixel_data <= active_s ? pix_src_s : 8'd0;
    end
  end

  assign VGA_state = state_r;

endmodule

// File: tb/tb_vga_out.sv
// Self-checking bench for vga_out: SRAM responder, per-cycle scoreboard,
// spot-check vector table, and hand sequences for reset corner cases.
module tb_vga_out;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] sram_data = 32'd0;
  logic        sram_busy = 1'b0;
  logic        data_en;
  logic        h_out;
  logic        v_out;
  logic [7:0]  pixel_data;
  logic [31:0] word_address_dest;
  logic [3:0]  byte_select;
  logic [1:0]  VGA_state;

  vga_out dut (
    .clk               (clk),
    .nrst              (nrst),
    .SRAM_data_in      (sram_data),
    .SRAM_busy         (sram_busy),
    .data_en           (data_en),
    .h_out             (h_out),
    .v_out             (v_out),
    .pixel_data        (pixel_data),
    .word_address_dest (word_address_dest),
    .byte_select       (byte_select),
    .VGA_state         (VGA_state)
  );

  always #20 clk = ~clk;

  typedef struct {
    int         h;
    int         v;
    logic       hout;
    logic       vout;
    logic [7:0] pix;
    logic [1:0] st;
  } vec_t;

  typedef struct {
    int          h;
    int          v;
    logic        hout;
    logic        vout;
    logic [7:0]  pix;
    logic        req;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   run_en = 1'b0;
  int   ur_line = 2;
  int   slow_idx = 80;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // The SRAM returns an address-derived word with four distinct bytes.
  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return {a[7:0] ^ 8'hC3, a[7:0] ^ 8'h5A, a[7:0] ^ 8'hA5, a[7:0]};
  endfunction

  // Expected registered outputs for counter value c (c cycles after release).
  function automatic exp_t model(input int c);
    exp_t        e;
    int          w;
    int          lane;
    int          nv;
    logic [31:0] wd;
    e.h    = c % 800;
    e.v    = c / 800;
    e.hout = (e.h >= 656 && e.h <= 751) ? 1'b0 : 1'b1;
    e.vout = (e.v >= 490 && e.v <= 491) ? 1'b0 : 1'b1;
    e.pix  = 8'h00;
    e.req  = 1'b0;
    e.addr = 32'd0;
    if (e.h < 640 && e.v < 480) begin
      w    = e.h / 16;
      lane = (e.h / 4) % 4;
      if (!((e.v == 0 && w == 0) || (e.v == ur_line && (w == 1 || w == 2)))) begin
        wd    = sram_word(32'((e.v / 4) * 40 + w));
        e.pix = wd[lane*8 +: 8];
      end
    end
    if (e.h % 16 == 0) begin
      if (e.v < 480 && e.h < 624 && !(e.v == ur_line && e.h == 16)) begin
        e.req  = 1'b1;
        e.addr = 32'((e.v / 4) * 40 + e.h / 16 + 1);
      end else if (e.h == 784) begin
        nv = (e.v == 524) ? 0 : e.v + 1;
        if (nv < 480) begin
          e.req  = 1'b1;
          e.addr = 32'((nv / 4) * 40);
        end
      end
    end
    return e;
  endfunction

  // SRAM responder: busy for 3 cycles per request, 20 for request number slow_idx.
  initial begin : sram_model
    int          cnt;
    int          req_idx;
    logic [31:0] a;
    cnt = 0;
    req_idx = 0;
    a = 32'd0;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        sram_busy = 1'b0;
        cnt = 0;
        req_idx = 0;
      end else if (data_en) begin
        a = word_address_dest;
        cnt = (req_idx == slow_idx) ? 20 : 3;
        req_idx++;
        sram_busy = 1'b1;
        sram_data = 32'hBAD0_BAD0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sram_busy = 1'b0;
          sram_data = sram_word(a);
        end
      end
    end
  end

  // Scoreboard: push the expectation at each active edge, and compare on the next falling edge.
  initial begin : scoreboard
    exp_t e;
    forever begin
      @(posedge clk);
      if (run_en) begin
        sb.push_back(model(cyc));
        cyc++;
      end else begin
        cyc = 0;
      end
      @(negedge clk);
      if (!run_en) begin
        sb.delete();
      end else if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("h_out h=%0d v=%0d", e.h, e.v), {31'd0, h_out}, {31'd0, e.hout});
        chk($sformatf("v_out h=%0d v=%0d", e.h, e.v), {31'd0, v_out}, {31'd0, e.vout});
        chk($sformatf("pixel h=%0d v=%0d", e.h, e.v), {24'd0, pixel_data}, {24'd0, e.pix});
        chk($sformatf("data_en h=%0d v=%0d", e.h, e.v), {31'd0, data_en}, {31'd0, e.req});
        chk($sformatf("byte_sel h=%0d v=%0d", e.h, e.v), {28'd0, byte_select},
            e.req ? 32'd15 : 32'd0);
        if (e.req) begin
          chk($sformatf("addr h=%0d v=%0d", e.h, e.v), word_address_dest, e.addr);
        end
      end
    end
  end

  // Wait until the sample of counter value tgt-1 is on the outputs.
  task automatic wait_cyc(input int tgt);
    int guard;
    guard = 0;
    while (cyc < tgt && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("cycle reach %0d", tgt), 32'(cyc), 32'(tgt));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " h_out"}, {31'd0, h_out}, 32'd1);
    chk({tag, " v_out"}, {31'd0, v_out}, 32'd1);
    chk({tag, " pixel"}, {24'd0, pixel_data}, 32'd0);
    chk({tag, " data_en"}, {31'd0, data_en}, 32'd0);
    chk({tag, " state"}, {30'd0, VGA_state}, 32'd0);
    chk({tag, " addr"}, word_address_dest, 32'd0);
    chk({tag, " byte_sel"}, {28'd0, byte_select}, 32'd0);
  endtask

  initial begin : main
    vec_t vt[26];
    int   guard;
    // {h, v, h_out, v_out, pixel, state}
    vt[0]  = '{0,   0, 1'b1, 1'b1, 8'h00, 2'd1};
    vt[1]  = '{15,  0, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[2]  = '{16,  0, 1'b1, 1'b1, 8'h01, 2'd1};
    vt[3]  = '{20,  0, 1'b1, 1'b1, 8'hA4, 2'd3};
    vt[4]  = '{27,  0, 1'b1, 1'b1, 8'h5B, 2'd0};
    vt[5]  = '{31,  0, 1'b1, 1'b1, 8'hC2, 2'd0};
    vt[6]  = '{639, 0, 1'b1, 1'b1, 8'hE4, 2'd0};
    vt[7]  = '{640, 0, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[8]  = '{655, 0, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[9]  = '{656, 0, 1'b0, 1'b1, 8'h00, 2'd0};
    vt[10] = '{751, 0, 1'b0, 1'b1, 8'h00, 2'd0};
    vt[11] = '{752, 0, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[12] = '{784, 0, 1'b1, 1'b1, 8'h00, 2'd1};
    vt[13] = '{4,   1, 1'b1, 1'b1, 8'hA5, 2'd3};
    vt[14] = '{16,  2, 1'b1, 1'b1, 8'h00, 2'd2};
    vt[15] = '{36,  2, 1'b1, 1'b1, 8'h00, 2'd3};
    vt[16] = '{48,  2, 1'b1, 1'b1, 8'h03, 2'd1};
    vt[17] = '{656, 3, 1'b0, 1'b1, 8'h00, 2'd0};
    vt[18] = '{752, 3, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[19] = '{784, 3, 1'b1, 1'b1, 8'h00, 2'd1};
    vt[20] = '{785, 3, 1'b1, 1'b1, 8'h00, 2'd2};
    vt[21] = '{788, 3, 1'b1, 1'b1, 8'h00, 2'd3};
    vt[22] = '{789, 3, 1'b1, 1'b1, 8'h00, 2'd0};
    vt[23] = '{0,   4, 1'b1, 1'b1, 8'h28, 2'd1};
    vt[24] = '{12,  4, 1'b1, 1'b1, 8'hEB, 2'd0};
    vt[25] = '{16,  4, 1'b1, 1'b1, 8'h29, 2'd1};

    // Power-on reset held for two cycles.
    ur_line  = 2;
    slow_idx = 80;
    nrst     = 1'b0;
    run_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");

    @(negedge clk);
    nrst   = 1'b1;
    run_en = 1'b1;

    for (int i = 0; i < 26; i++) begin
      wait_cyc(vt[i].v * 800 + vt[i].h + 1);
      chk($sformatf("vec%0d h_out", i), {31'd0, h_out}, {31'd0, vt[i].hout});
      chk($sformatf("vec%0d v_out", i), {31'd0, v_out}, {31'd0, vt[i].vout});
      chk($sformatf("vec%0d pixel", i), {24'd0, pixel_data}, {24'd0, vt[i].pix});
      chk($sformatf("vec%0d state", i), {30'd0, VGA_state}, {30'd0, vt[i].st});
    end

    // Reset asserted mid-cycle while a fetch is waiting on the SRAM.
    guard = 0;
    while (VGA_state != 2'd2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach WAIT", {30'd0, VGA_state}, 32'd2);
    @(posedge clk);
    #5;
    run_en = 1'b0;
    nrst   = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst held");

    // The new frame fetches normally, with no slow request.
    ur_line  = -1;
    slow_idx = -1;
    nrst     = 1'b1;
    run_en   = 1'b1;
    wait_cyc(17);
    chk("refetch pixel h16", {24'd0, pixel_data}, 32'h01);
    wait_cyc(785);
    chk("refetch line1 req", {31'd0, data_en}, 32'd1);
    chk("refetch line1 addr", word_address_dest, 32'd0);
    wait_cyc(805);
    chk("refetch pixel line1", {24'd0, pixel_data}, 32'hA5);
    wait_cyc(900);

    run_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
